frame_sequencer: RTL

- Per-frame controller for the jumpy_hawk game datapath.
- Divides the 50 MHz clock into a frame tick.
- Each frame it runs, in order: erase bird, erase wall, physics update, draw wall, draw bird, collision check.
- Issues one draw job at a time to the pixel-drawing datapath over a start/done handshake.
- Latches player flap presses and signals score increments, clears and game-over to the datapath and HEX score logic.

---
 rtl/jumpy_pkg.sv | 34 +++
 rtl/key_edge_sync.sv | 30 +++
 rtl/frame_sequencer.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/jumpy_pkg.sv
// Shared definitions for the jumpy_hawk frame sequencer: state and draw-target
// encodings and the default frame divider.
package jumpy_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_WAIT_TICK  = 4'd1,
    ST_ERASE_BIRD = 4'd2,
    ST_ERASE_WALL = 4'd3,
    ST_UPDATE     = 4'd4,
    ST_DRAW_WALL  = 4'd5,
    ST_DRAW_BIRD  = 4'd6,
    ST_CHECK      = 4'd7,
    ST_GAMEOVER   = 4'd8,
    ST_CLEAR      = 4'd9
  } state_e;

  typedef enum logic [1:0] {
    OBJ_BIRD   = 2'd0,
    OBJ_WALL   = 2'd1,
    OBJ_SCREEN = 2'd2
  } obj_e;

  // 60 Hz frame tick from the 50 MHz board clock
  localparam int DEF_FRAME_DIV = 833333;
  localparam int DEF_CNT_W     = 20;

  // States that own one draw job on the pixel datapath
  function automatic logic is_draw_state(input state_e s);
    return (s == ST_ERASE_BIRD) || (s == ST_ERASE_WALL) ||
           (s == ST_DRAW_WALL)  || (s == ST_DRAW_BIRD)  || (s == ST_CLEAR);
  endfunction

endpackage

// File: rtl/key_edge_sync.sv
// Two-flop synchronizer for an active-low push button followed by a registered
// falling-edge detector. fall_o pulses for one cycle, three cycles after the
// key goes low. All flops reset to "released".
module key_edge_sync (
  input  logic clk_i,
  input  logic reset_i,
  input  logic key_n_i,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q, fall_q;

  // Synchronize the raw key and register a one-cycle press pulse
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      fall_q  <= prev_q & ~sync2_q;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/frame_sequencer.sv
// Per-frame controller for the jumpy_hawk datapath. A free-running divider
// produces the frame tick; each frame the FSM erases bird and wall, advances
// physics, redraws wall and bird and checks for collision, issuing one draw
// job at a time over draw_start/draw_done.
// Handshake: draw_start is a one-cycle pulse in the first cycle of a draw
// state; draw_obj/draw_erase hold for the whole state; draw_done is a
// one-cycle pulse, ignored in the start cycle, and the state advances on the
// edge that samples it.
// Optional build macro FRAME_SEQUENCER_PAUSE_EN adds pause_n/paused.
module frame_sequencer
  import jumpy_pkg::*;
#(
  parameter int FRAME_DIV = DEF_FRAME_DIV,
  parameter int CNT_W     = DEF_CNT_W
) (
`ifdef FRAME_SEQUENCER_PAUSE_EN
  input  logic       pause_n,
  output logic       paused,
`endif
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  input  logic       draw_done,
  input  logic       collision,
  input  logic       wall_passed,
  output logic       draw_start,
  output logic [1:0] draw_obj,
  output logic       draw_erase,
  output logic       update_en,
  output logic       flap,
  output logic       score_inc,
  output logic       score_clr,
  output logic       game_over,
  output logic [3:0] state_out,
  output logic       missed_tick
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FRAME_DIV - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic             pend_q, pend_d;
  logic             first_q;
  logic             flap_edge;
  logic             flap_ok;
  logic             pause_act;
  logic             done_ok;
  obj_e             obj;

  key_edge_sync u_flap_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .key_n_i (key_n),
    .fall_o  (flap_edge)
  );

`ifdef FRAME_SEQUENCER_PAUSE_EN
  logic pause_edge;
  logic paused_q;

  key_edge_sync u_pause_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .key_n_i (pause_n),
    .fall_o  (pause_edge)
  );

  // Pause flag toggles per press and drops when the game ends
  always_ff @(posedge clk) begin
    if (reset) begin
      paused_q <= 1'b0;
    end else if (state_d == ST_GAMEOVER && state_q != ST_GAMEOVER) begin
      paused_q <= 1'b0;
    end else if (pause_edge) begin
      paused_q <= ~paused_q;
    end
  end

  assign pause_act = paused_q;
  assign paused    = paused_q;
`else
  assign pause_act = 1'b0;
`endif

  // Frame divider: tick marks the last count of each frame period
  always_comb begin
    tick  = (cnt_q == CNT_MAX);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // State, divider, pending-flap and draw-start-cycle registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      first_q <= is_draw_state(state_d) && (state_d != state_q);
    end
  end

  // Next state and per-state outputs
  always_comb begin
    state_d    = state_q;
    obj        = OBJ_BIRD;
    draw_erase = 1'b0;
    update_en  = 1'b0;
    flap       = 1'b0;
    score_inc  = 1'b0;
    score_clr  = 1'b0;
    game_over  = 1'b0;
    flap_ok    = flap_edge && !pause_act;
    done_ok    = draw_done && !first_q;
    case (state_q)
      ST_IDLE: begin
        if (flap_edge) begin
          state_d   = ST_CLEAR;
          score_clr = 1'b1;
        end
      end
      ST_CLEAR: begin
        obj        = OBJ_SCREEN;
        draw_erase = 1'b1;
        if (done_ok) state_d = ST_WAIT_TICK;
      end
      ST_WAIT_TICK: begin
        if (tick && !pause_act) state_d = ST_ERASE_BIRD;
      end
      ST_ERASE_BIRD: begin
        obj        = OBJ_BIRD;
        draw_erase = 1'b1;
        if (done_ok) state_d = ST_ERASE_WALL;
      end
      ST_ERASE_WALL: begin
        obj        = OBJ_WALL;
        draw_erase = 1'b1;
        if (done_ok) state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        update_en = 1'b1;
        // A press landing in this very cycle joins the current flap
        flap      = pend_q | flap_ok;
        state_d   = ST_DRAW_WALL;
      end
      ST_DRAW_WALL: begin
        obj = OBJ_WALL;
        if (done_ok) state_d = ST_DRAW_BIRD;
      end
      ST_DRAW_BIRD: begin
        obj = OBJ_BIRD;
        if (done_ok) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        if (collision) begin
          state_d = ST_GAMEOVER;
        end else begin
          score_inc = wall_passed;
          state_d   = ST_WAIT_TICK;
        end
      end
      ST_GAMEOVER: begin
        game_over = 1'b1;
        if (flap_edge) begin
          state_d   = ST_CLEAR;
          score_clr = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Flap latch: set during a running frame, consumed by the physics update
  always_comb begin
    pend_d = pend_q;
    if (state_q == ST_UPDATE) begin
      pend_d = 1'b0;
    end else if (flap_ok && (state_q == ST_WAIT_TICK || is_draw_state(state_q))) begin
      pend_d = 1'b1;
    end
  end

  // Draw launch pulse and overrun indication
  always_comb begin
    draw_start  = is_draw_state(state_q) && first_q;
    missed_tick = tick && (state_q != ST_WAIT_TICK) &&
                  (state_q != ST_IDLE) && (state_q != ST_GAMEOVER);
  end

  assign draw_obj  = logic'(1'b0) ? 2'b00 : obj;
  assign state_out = state_q;

endmodule
